cnn_layer_sched: RTL

CNN_LAYER_SCHED -- requirements
Module: cnn_layer_sched

---
 rtl/cnn_layer_sched.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/cnn_layer_sched.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_sched
// Purpose  : Frame scheduler that time-multiplexes one shared calculation
//            unit and one ping-pong buffer across NUM_LAYERS layer engines.
//            A frame runs the layers selected by the captured mask in
//            ascending index order. Each layer gets a one-cycle ARM gap so
//            the shared mux settles before its enable rises.
// Optional : define LAYER_SCHED_WDOG_EN to add a per-layer watchdog that
//            aborts a frame when a layer stays in RUN for WDOG_CYCLES cycles.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            start_i            - frame start pulse (accepted in IDLE only)
//            layer_mask_i       - per-layer run enable, captured on start
//            layer_done_i       - per-layer completion pulses
//            layer_buf_we_i     - per-layer buffer write enables
//            layer_en_o         - one-hot enable of the running layer
//            select_o           - index of current layer (shared mux select)
//            buf_we_o           - write enable muxed from the running layer
//            bank_sel_o         - ping-pong bank, toggles per finished layer
//            busy_o             - frame in progress
//            frame_done_o       - one-cycle pulse at end of frame
//            err_o              - sticky protocol error flag
//            frame_cnt_o        - completed frame count (wraps)
//            timeout_o          - one-cycle watchdog pulse
// Revision : 1.0 - initial release
// ============================================================================
module cnn_layer_sched #(
  parameter int NUM_LAYERS  = 5,
  parameter int SEL_W       = 8,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [NUM_LAYERS-1:0] layer_mask_i,
  input  logic [NUM_LAYERS-1:0] layer_done_i,
  input  logic [NUM_LAYERS-1:0] layer_buf_we_i,
  output logic [NUM_LAYERS-1:0] layer_en_o,
  output logic [SEL_W-1:0]      select_o,
  output logic                  buf_we_o,
  output logic                  bank_sel_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  err_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [NUM_LAYERS-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  bank_q, bank_d;
  logic                  err_q, err_d;
  logic [15:0]           cnt_q, cnt_d;

  // Decoded one-hot of the current index; shared by enable, write mux and
  // done qualification so all three agree on which layer is active.
  logic [NUM_LAYERS-1:0] active_vec;
  logic [SEL_W-1:0]      first_idx;
  logic [SEL_W-1:0]      next_idx;
  logic                  next_found;
  logic                  active_done;
  logic                  stray_done;
  logic                  wdog_expire;

  always_comb begin
    active_vec = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (sel_q == SEL_W'(i)) active_vec[i] = 1'b1;
    end
  end

  // Lowest set bit of the incoming mask. Scanning downward lets the last
  // hit (the lowest index) win.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_mask_i[i]) first_idx = SEL_W'(i);
    end
  end

  // Lowest captured-mask index strictly above the current one.
  always_comb begin
    next_idx   = sel_q;
    next_found = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (mask_q[i] && (SEL_W'(i) > sel_q)) begin
        next_idx   = SEL_W'(i);
        next_found = 1'b1;
      end
    end
  end

  assign active_done = (state_q == S_RUN) && (|(layer_done_i & active_vec));
  // Outside RUN every done bit is unexpected; inside RUN only non-active ones.
  assign stray_done  = (state_q == S_RUN) ? (|(layer_done_i & ~active_vec))
                                          : (|layer_done_i);

`ifdef LAYER_SCHED_WDOG_EN
  localparam logic [31:0] C_WDOG_LAST = 32'(WDOG_CYCLES - 1);

  logic [31:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;

  // wdog_q counts RUN cycles already spent on the current layer; the abort
  // fires at the end of the WDOG_CYCLES-th RUN cycle if no done arrived.
  assign wdog_expire = (state_q == S_RUN) && !active_done &&
                       (wdog_q == C_WDOG_LAST);

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_ARM)      wdog_d = '0;
    else if (state_q == S_RUN) wdog_d = wdog_q + 32'd1;
    timeout_d = wdog_expire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    bank_d  = bank_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (|layer_mask_i) begin
            mask_d  = layer_mask_i;
            sel_d   = first_idx;
            err_d   = 1'b0;
            state_d = S_ARM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ARM: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (active_done) begin
          bank_d = ~bank_q;
          if (next_found) begin
            sel_d   = next_idx;
            state_d = S_ARM;
          end else begin
            state_d = S_DONE;
          end
        end else if (wdog_expire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A stray done in the same cycle as an accepted start must still flag.
    if (stray_done) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
      bank_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      bank_q  <= bank_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign layer_en_o   = (state_q == S_RUN) ? active_vec : '0;
  assign select_o     = sel_q;
  assign buf_we_o     = (state_q == S_RUN) && (|(layer_buf_we_i & active_vec));
  assign bank_sel_o   = bank_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = (state_q == S_DONE);
  assign err_o        = err_q;
  assign frame_cnt_o  = cnt_q;

endmodule
`default_nettype wire
